// File: rtl/alu_pkg.sv
// Shared ALU interface definitions: the 4-bit ALUOp encoding, the MIPS
// opcode/funct values the issue stage decodes, and the default datapath width.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    // ALUOp encoding seen by the ALU
    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_JUMP = 4'b1010;
    localparam logic [3:0] ALU_LW   = 4'b1011;
    localparam logic [3:0] ALU_SW   = 4'b1100;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/alu_op_decoder.sv
// Pure combinational MIPS decoder: opcode/funct -> ALUOp plus the control
// bits the issue stage needs. Also usable by an ALU bench as golden encoding.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       uses_imm,   // operand b is the sign-extended immediate
    output logic       reads_rt,   // rt is a source register (hazard relevant)
    output logic       rd_sel,     // 1: dest is instr[15:11], 0: dest is rt
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       illegal
);

    // Decode the opcode, and for R-type the funct field, into controls
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_op    = ALU_NOP;
        uses_imm  = 1'b0;
        reads_rt  = 1'b0;
        rd_sel    = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                // rt is read by any R-type encoding, so hazards key on opcode
                reads_rt = 1'b1;
                rd_sel   = 1'b1;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_MULT:         alu_op = ALU_MULT;
                    default: begin
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_op    = ALU_ADD;
                uses_imm  = 1'b1;
                reg_write = 1'b1;
            end
            OP_LW: begin
                alu_op    = ALU_LW;
                uses_imm  = 1'b1;
                reg_write = 1'b1;
                mem_read  = 1'b1;
            end
            OP_SW: begin
                alu_op    = ALU_SW;
                uses_imm  = 1'b1;
                reads_rt  = 1'b1;
                mem_write = 1'b1;
            end
            OP_BEQ: begin
                alu_op   = ALU_BEQ;
                reads_rt = 1'b1;
            end
            OP_JUMP: alu_op = ALU_JUMP;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes the ID instruction, selects ALU operands and
// registers them into the EX pipeline register. Inserts a bubble on a
// load-use hazard or flush, and holds the register while downstream stalls.
module id_ex_alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W     = ALU_DATA_W,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [3:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_a,
    output logic [DATA_W-1:0]     ex_b,
    output logic [DATA_W-1:0]     ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_illegal
);

    logic [3:0]            dec_alu_op;
    logic                  dec_uses_imm;
    logic                  dec_reads_rt;
    logic                  dec_rd_sel;
    logic                  dec_reg_write;
    logic                  dec_mem_read;
    logic                  dec_mem_write;
    logic                  dec_illegal;

    logic [REG_ADDR_W-1:0] rs_idx;
    logic [REG_ADDR_W-1:0] rt_idx;
    logic [REG_ADDR_W-1:0] dest_idx;
    logic [DATA_W-1:0]     imm_ext;
    logic                  id_reg_write;
    logic                  hazard;

    alu_op_decoder u_dec (
        .opcode    (id_instr[31:26]),
        .funct     (id_instr[5:0]),
        .alu_op    (dec_alu_op),
        .uses_imm  (dec_uses_imm),
        .reads_rt  (dec_reads_rt),
        .rd_sel    (dec_rd_sel),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .illegal   (dec_illegal)
    );

    assign rs_idx   = REG_ADDR_W'(id_instr[25:21]);
    assign rt_idx   = REG_ADDR_W'(id_instr[20:16]);
    assign dest_idx = dec_rd_sel ? REG_ADDR_W'(id_instr[15:11]) : rt_idx;
    assign imm_ext  = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

    // Writes to $0 are discarded, so never advertise them downstream
    assign id_reg_write = dec_reg_write & (dest_idx != '0);

    // Load in EX whose result a source operand of the ID instruction needs
    assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == rs_idx) | ((ex_rd == rt_idx) & dec_reads_rt));

    assign id_stall = hazard | stall_in;

    // EX pipeline register: reset > hold > bubble (flush/hazard/empty) > load
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // field samples pre-edge values regardless of statement order.
        if (reset || (!stall_in && (flush || hazard || !id_valid))) begin
            // NOTE: datapath fields are cleared too, not just the valid bit,
            // so a bubble presents deterministic all-zero values to the ALU.
            ex_valid      <= 1'b0;
            ex_alu_op     <= ALU_NOP;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!stall_in) begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= dec_alu_op;
            ex_a          <= id_rs_data;
            ex_b          <= dec_uses_imm ? imm_ext : id_rt_data;
            ex_store_data <= id_rt_data;
            // Non-writing instructions carry index 0 so nothing downstream
            // can mistake them for a producer
            ex_rd         <= dec_reg_write ? dest_idx : '0;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= dec_mem_read;
            ex_mem_write  <= dec_mem_write;
            ex_illegal    <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Self-checking bench for id_ex_alu_issue: directed instruction sequence,
// a cycle-level reference model built from the instruction-set rules, a
// per-cycle compare process, and literal expectations pinning key points.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_rs_data = '0;
    logic [31:0] id_rt_data = '0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        id_stall;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    id_ex_alu_issue dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .stall_in      (stall_in),
        .flush         (flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_illegal    (ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } exp_t;

    exp_t m = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the EX register must hold after issuing one instruction
    function automatic exp_t issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t r;
        int op6, fn, dest;
        logic [31:0] imm;
        op6 = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        imm = {{16{ins[15]}}, ins[15:0]};
        r = '0;
        r.valid = 1'b1;
        r.a = rs;
        r.b = rt;
        r.sd = rt;
        dest = 0;
        case (op6)
            'h00: begin
                case (fn)
                    'h20, 'h21: r.op = 4'd1;
                    'h22, 'h23: r.op = 4'd2;
                    'h24: r.op = 4'd3;
                    'h25: r.op = 4'd4;
                    'h18: r.op = 4'd5;
                    'h26: r.op = 4'd6;
                    'h27: r.op = 4'd7;
                    'h2A: r.op = 4'd8;
                    default: r.ill = 1'b1;
                endcase
                if (!r.ill) dest = int'(ins[15:11]);
            end
            'h08: begin r.op = 4'd1;  r.b = imm; dest = int'(ins[20:16]); end
            'h23: begin r.op = 4'd11; r.b = imm; dest = int'(ins[20:16]); r.mr = 1'b1; end
            'h2B: begin r.op = 4'd12; r.b = imm; r.mw = 1'b1; end
            'h04: r.op = 4'd9;
            'h02: r.op = 4'd10;
            default: r.ill = 1'b1;
        endcase
        r.rd = 5'(dest);
        r.rw = (dest != 0) && !r.ill && (op6 == 'h00 || op6 == 'h08 || op6 == 'h23);
        return r;
    endfunction

    // Load-use: the loaded register is a source of the ID instruction
    function automatic logic model_hazard();
        logic [31:0] ins;
        int src1, src2;
        bit uses_rt;
        ins = id_instr;
        src1 = int'(ins[25:21]);
        src2 = int'(ins[20:16]);
        uses_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h04) || (ins[31:26] == 6'h2B);
        return id_valid && m.valid && m.mr && (m.rd != 0) &&
               ((int'(m.rd) == src1) || (uses_rt && int'(m.rd) == src2));
    endfunction

    // Reference model of the EX register
    always @(posedge clk) begin
        if (reset) m <= '0;
        else if (stall_in) m <= m;
        else if (flush || model_hazard() || !id_valid) m <= '0;
        else m <= issue(id_instr, id_rs_data, id_rt_data);
    end

    // Compare DUT against the model on every falling edge once reset has run
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_valid", 32'(ex_valid), 32'(m.valid));
            check("cmp_op",    32'(ex_alu_op), 32'(m.op));
            check("cmp_a",     ex_a, m.a);
            check("cmp_b",     ex_b, m.b);
            check("cmp_sd",    ex_store_data, m.sd);
            check("cmp_rd",    32'(ex_rd), 32'(m.rd));
            check("cmp_rw",    32'(ex_reg_write), 32'(m.rw));
            check("cmp_mr",    32'(ex_mem_read), 32'(m.mr));
            check("cmp_mw",    32'(ex_mem_write), 32'(m.mw));
            check("cmp_ill",   32'(ex_illegal), 32'(m.ill));
            check("cmp_stall", 32'(id_stall), 32'(model_hazard() | stall_in));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic st, input logic fl);
        id_valid = v;
        id_instr = ins;
        id_rs_data = rsd;
        id_rt_data = rtd;
        stall_in = st;
        flush = fl;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_op", 32'(ex_alu_op), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_stall", 32'(id_stall), 32'd0);

        // add $3,$1,$2
        drive(1, 32'h00221820, 32'd5, 32'd7, 0, 0); tick();
        check("add_valid", 32'(ex_valid), 32'd1);
        check("add_op", 32'(ex_alu_op), 32'h1);
        check("add_a", ex_a, 32'd5);
        check("add_b", ex_b, 32'd7);
        check("add_rd", 32'(ex_rd), 32'd3);
        check("add_rw", 32'(ex_reg_write), 32'd1);

        // lw $4,-4($1)
        drive(1, 32'h8C24FFFC, 32'h100, 32'h55, 0, 0); tick();
        check("lw_op", 32'(ex_alu_op), 32'hB);
        check("lw_b", ex_b, 32'hFFFFFFFC);
        check("lw_rd", 32'(ex_rd), 32'd4);
        check("lw_mr", 32'(ex_mem_read), 32'd1);

        // sw $5,8($2): independent of $4, no stall
        drive(1, 32'hAC450008, 32'h200, 32'h1234, 0, 0);
        check("sw_nostall", 32'(id_stall), 32'd0);
        tick();
        check("sw_op", 32'(ex_alu_op), 32'hC);
        check("sw_b", ex_b, 32'd8);
        check("sw_sd", ex_store_data, 32'h1234);
        check("sw_rw", 32'(ex_reg_write), 32'd0);

        // lw $4,0($1) then sub $6,$4,$2 -> one bubble
        drive(1, 32'h8C240000, 32'h300, 32'h0, 0, 0); tick();
        drive(1, 32'h00823022, 32'd20, 32'd3, 0, 0);
        check("lu_stall", 32'(id_stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubble_op", 32'(ex_alu_op), 32'd0);
        check("lu_release", 32'(id_stall), 32'd0);
        tick();
        check("lu_sub_op", 32'(ex_alu_op), 32'h2);
        check("lu_sub_rd", 32'(ex_rd), 32'd6);

        // lw $0 followed by a reader of $0 -> no stall
        drive(1, 32'h8C200000, 32'h40, 32'h0, 0, 0); tick();
        check("lw0_rw", 32'(ex_reg_write), 32'd0);
        drive(1, 32'h00023022, 32'd0, 32'd9, 0, 0);
        check("lw0_nostall", 32'(id_stall), 32'd0);
        tick();
        check("lw0_sub_valid", 32'(ex_valid), 32'd1);

        // slt $8,$1,$2 held by downstream stall for three cycles
        drive(1, 32'h0022402A, 32'd1, 32'd2, 0, 0); tick();
        drive(1, 32'h00430825, 32'hF0, 32'h0F, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_stall", 32'(id_stall), 32'd1);
            tick();
            check("hold_op", 32'(ex_alu_op), 32'h8);
            check("hold_a", ex_a, 32'd1);
        end
        drive(1, 32'h00430825, 32'hF0, 32'h0F, 0, 0); tick();
        check("rel_or_op", 32'(ex_alu_op), 32'h4);
        check("rel_or_rd", 32'(ex_rd), 32'd1);

        // flush squashes a valid or
        drive(1, 32'h00430825, 32'hF0, 32'h0F, 0, 1); tick();
        check("flush_valid", 32'(ex_valid), 32'd0);
        drive(1, 32'h0022402A, 32'd1, 32'd2, 0, 0); tick();
        // flush together with stall -> held
        drive(1, 32'h00430825, 32'hF0, 32'h0F, 1, 1); tick();
        check("flush_hold_op", 32'(ex_alu_op), 32'h8);
        drive(1, 32'h00430825, 32'hF0, 32'h0F, 0, 1); tick();
        check("flush_late_valid", 32'(ex_valid), 32'd0);

        // illegal encodings
        drive(1, 32'hFC000000, 32'd1, 32'd2, 0, 0); tick();
        check("ill_op_flag", 32'(ex_illegal), 32'd1);
        check("ill_op_op", 32'(ex_alu_op), 32'd0);
        drive(1, 32'h0022183F, 32'd1, 32'd2, 0, 0); tick();
        check("ill_fn_flag", 32'(ex_illegal), 32'd1);
        check("ill_fn_rw", 32'(ex_reg_write), 32'd0);

        // addi to $0, then addi with negative immediate
        drive(1, 32'h20200005, 32'd10, 32'd0, 0, 0); tick();
        check("addi0_rw", 32'(ex_reg_write), 32'd0);
        check("addi0_b", ex_b, 32'd5);
        drive(1, 32'h2022FFFF, 32'd10, 32'd0, 0, 0); tick();
        check("addineg_b", ex_b, 32'hFFFFFFFF);
        check("addineg_rd", 32'(ex_rd), 32'd2);

        // beq, jump, empty ID slot
        drive(1, 32'h10220003, 32'd4, 32'd4, 0, 0); tick();
        check("beq_op", 32'(ex_alu_op), 32'h9);
        drive(1, 32'h08000010, 32'd0, 32'd0, 0, 0); tick();
        check("j_op", 32'(ex_alu_op), 32'hA);
        drive(0, 32'h00221820, 32'd5, 32'd7, 0, 0); tick();
        check("empty_valid", 32'(ex_valid), 32'd0);

        // lw $9 then beq reading $9 through rt -> stall
        drive(1, 32'h8C090000, 32'h0, 32'h0, 0, 0); tick();
        drive(1, 32'h10290002, 32'd1, 32'd1, 0, 0);
        check("beq_rt_stall", 32'(id_stall), 32'd1);
        tick(); tick();

        // reset during a downstream stall
        drive(1, 32'h00221820, 32'd5, 32'd7, 0, 0); tick();
        drive(1, 32'h00221820, 32'd5, 32'd7, 1, 0);
        reset = 1'b1;
        tick();
        check("rst_stall_valid", 32'(ex_valid), 32'd0);
        check("rst_stall_idstall", 32'(id_stall), 32'd1);
        reset = 1'b0;
        drive(0, 32'h0, 32'd0, 32'd0, 0, 0);
        check("rst_stall_free", 32'(id_stall), 32'd0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
